// File: rtl/linear_proj_out_collector.sv
// Collects one wide result beat per flag from the projection matmul array and
// serializes it into per-module BRAM writes at row-major tile addresses.
module linear_proj_out_collector #(
  parameter int WIDTH_OUT      = 16,
  parameter int BLOCK_SIZE     = 2,
  parameter int NUM_CORES_A    = 2,
  parameter int NUM_CORES_B    = 1,
  parameter int TOTAL_MODULES  = 4,
  parameter int ROW_SIZE_MAT_C = 1,
  parameter int COL_SIZE_MAT_C = 1,
  parameter int MODULE_W       = WIDTH_OUT * BLOCK_SIZE * BLOCK_SIZE * NUM_CORES_A * NUM_CORES_B,
  parameter int MAX_FLAG       = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
  parameter int ADDR_WIDTH     = (MAX_FLAG * TOTAL_MODULES > 1) ? $clog2(MAX_FLAG * TOTAL_MODULES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TOTAL_MODULES*MODULE_W-1:0] in_data,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [MODULE_W-1:0]               wr_data,
  output logic [$clog2(MAX_FLAG+1)-1:0]     flag_cnt,
  output logic                              busy,
  output logic                              done
);

  localparam int M_W   = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
  localparam int ROW_W = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
  localparam int COL_W = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;
  localparam int FC_W  = $clog2(MAX_FLAG + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [TOTAL_MODULES*MODULE_W-1:0] cap_q, cap_d;
  logic [M_W-1:0]                    m_q, m_d;
  logic [ROW_W-1:0]                  row_q, row_d;
  logic [COL_W-1:0]                  col_q, col_d;
  logic [FC_W-1:0]                   flag_cnt_q, flag_cnt_d;
  logic                              wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]             wr_addr_q, wr_addr_d;
  logic [MODULE_W-1:0]               wr_data_q, wr_data_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              last_beat, final_flag, ready_c, accept;

  // Write outputs are derived from the next state so they line up with the state register.
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    m_d        = m_q;
    row_d      = row_q;
    col_d      = col_q;
    flag_cnt_d = flag_cnt_q;
    last_beat  = (state_q == S_DRAIN) && (m_q == M_W'(TOTAL_MODULES - 1));
    final_flag = (flag_cnt_q == FC_W'(MAX_FLAG - 1));
    ready_c    = (state_q == S_WAIT) || (last_beat && !final_flag);
    accept     = ready_c && in_valid;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WAIT;
          m_d        = '0;
          row_d      = '0;
          col_d      = '0;
          flag_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (accept) begin
          state_d = S_DRAIN;
          m_d     = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (!last_beat) begin
          m_d = m_q + M_W'(1);
        end else begin
          m_d        = '0;
          flag_cnt_d = flag_cnt_q + FC_W'(1);
          if (col_q == COL_W'(COL_SIZE_MAT_C - 1)) begin
            col_d = '0;
            row_d = (row_q == ROW_W'(ROW_SIZE_MAT_C - 1)) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (final_flag) begin
            state_d = S_DONE;
          end else if (accept) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      cap_d = in_data;
    end else begin
      cap_d = cap_q;
    end

    wr_en_d = (state_d == S_DRAIN);
    if (wr_en_d) begin
      wr_addr_d = ADDR_WIDTH'((32'(row_d) * COL_SIZE_MAT_C + 32'(col_d)) * TOTAL_MODULES + 32'(m_d));
      wr_data_d = cap_d[32'(m_d)*MODULE_W +: MODULE_W];
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
    busy_d = (state_d == S_WAIT) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cap_q      <= '0;
      m_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      flag_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      m_q        <= m_d;
      row_q      <= row_d;
      col_q      <= col_d;
      flag_cnt_q <= flag_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = ready_c;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign flag_cnt = flag_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_linear_proj_out_collector.sv
// Directed bench for linear_proj_out_collector: default config, a 2x3 tile
// config (continuous, gapped, reset mid-drain) and a single-module config.
module tb_linear_proj_out_collector;

  logic clk;
  logic rst;

  // Default config: ROW=COL=1, TM=4
  logic         start_a, in_valid_a, in_ready_a, wr_en_a, busy_a, done_a;
  logic [511:0] in_data_a;
  logic [1:0]   wr_addr_a;
  logic [127:0] wr_data_a;
  logic [0:0]   flag_cnt_a;

  // ROW=2, COL=3, TM=4
  logic         start_b, in_valid_b, in_ready_b, wr_en_b, busy_b, done_b;
  logic [511:0] in_data_b;
  logic [4:0]   wr_addr_b;
  logic [127:0] wr_data_b;
  logic [2:0]   flag_cnt_b;

  // ROW=1, COL=4, TM=1
  logic         start_c, in_valid_c, in_ready_c, wr_en_c, busy_c, done_c;
  logic [127:0] in_data_c;
  logic [1:0]   wr_addr_c;
  logic [127:0] wr_data_c;
  logic [2:0]   flag_cnt_c;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  linear_proj_out_collector dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .flag_cnt(flag_cnt_a), .busy(busy_a), .done(done_a)
  );

  linear_proj_out_collector #(.ROW_SIZE_MAT_C(2), .COL_SIZE_MAT_C(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .flag_cnt(flag_cnt_b), .busy(busy_b), .done(done_b)
  );

  linear_proj_out_collector #(.TOTAL_MODULES(1), .COL_SIZE_MAT_C(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .flag_cnt(flag_cnt_c), .busy(busy_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] slice_a(input int m);
    return {32{4'(m + 1)}};
  endfunction

  function automatic logic [127:0] slice_b(input int f, input int m);
    return {8{16'hB000 + 16'(f * 16 + m)}};
  endfunction

  function automatic logic [127:0] slice_c(input int f);
    return {8{16'hC0D0 + 16'(f)}};
  endfunction

  function automatic logic [511:0] beat_b(input int f);
    logic [511:0] v;
    for (int m = 0; m < 4; m++) v[m*128 +: 128] = slice_b(f, m);
    return v;
  endfunction

  task automatic chk_reset_b(input string tag);
    chk({tag, "_rdy"},  128'(in_ready_b), 128'(0));
    chk({tag, "_wren"}, 128'(wr_en_b),    128'(0));
    chk({tag, "_addr"}, 128'(wr_addr_b),  128'(0));
    chk({tag, "_data"}, wr_data_b,        128'(0));
    chk({tag, "_fcnt"}, 128'(flag_cnt_b), 128'(0));
    chk({tag, "_busy"}, 128'(busy_b),     128'(0));
    chk({tag, "_done"}, 128'(done_b),     128'(0));
  endtask

  // Continuous valid on the 2x3 config; optional start pulse while busy.
  task automatic run_cont_b(input bit bump);
    int b;
    bit exp_rdy, exp_wr;
    b = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      start_b = (bump && k == 10) ? 1'b1 : 1'b0;
      exp_rdy = (k == 1) || (k >= 5 && k <= 21 && (k - 5) % 4 == 0);
      exp_wr  = (k >= 2 && k <= 25);
      chk("cont_rdy",  128'(in_ready_b), 128'(exp_rdy));
      chk("cont_wren", 128'(wr_en_b),    128'(exp_wr));
      chk("cont_busy", 128'(busy_b),     128'(k <= 25));
      chk("cont_done", 128'(done_b),     128'(k == 26));
      if (exp_wr) begin
        chk("cont_addr", 128'(wr_addr_b), 128'(k - 2));
        chk("cont_data", wr_data_b, slice_b((k - 2) / 4, (k - 2) % 4));
      end
      if (k == 26) chk("cont_fcnt", 128'(flag_cnt_b), 128'(6));
      in_valid_b = (b < 6);
      in_data_b  = beat_b(b);
      if (exp_rdy && b < 6) b++;
    end
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("cont_done_end", 128'(done_b), 128'(0));
    chk("cont_fcnt_hold", 128'(flag_cnt_b), 128'(6));
  endtask

  // Gapped valid on the 2x3 config: idle cycles between beats.
  task automatic run_gap_b();
    int f, p;
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      f = (k - 1) / 8;
      p = (k - 1) % 8;
      if (k <= 45) begin
        chk("gap_wren", 128'(wr_en_b),    128'(p >= 1 && p <= 4));
        chk("gap_rdy",  128'(in_ready_b), 128'((p == 0) || (p >= 5) || (p == 4 && f < 5)));
        chk("gap_busy", 128'(busy_b),     128'(1));
        chk("gap_done", 128'(done_b),     128'(0));
        if (p >= 1 && p <= 4) begin
          chk("gap_addr", 128'(wr_addr_b), 128'(4 * f + p - 1));
          chk("gap_data", wr_data_b, slice_b(f, p - 1));
        end
        if (p >= 5) begin
          chk("gap_addr_hold", 128'(wr_addr_b), 128'(4 * f + 3));
          chk("gap_data_hold", wr_data_b, slice_b(f, 3));
        end
      end else begin
        chk("gap_done_end", 128'(done_b),     128'(1));
        chk("gap_busy_end", 128'(busy_b),     128'(0));
        chk("gap_wren_end", 128'(wr_en_b),    128'(0));
        chk("gap_fcnt_end", 128'(flag_cnt_b), 128'(6));
      end
      in_valid_b = (p == 0 && k <= 41);
      in_data_b  = beat_b(f);
    end
    in_valid_b = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int b;
    bit exp_rdy;
    rst = 1'b1;
    start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    start_c = 1'b0; in_valid_c = 1'b0; in_data_c = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_rdy",  128'(in_ready_a), 128'(0));
    chk("rst_a_wren", 128'(wr_en_a),    128'(0));
    chk("rst_a_addr", 128'(wr_addr_a),  128'(0));
    chk("rst_a_data", wr_data_a,        128'(0));
    chk("rst_a_fcnt", 128'(flag_cnt_a), 128'(0));
    chk("rst_a_busy", 128'(busy_a),     128'(0));
    chk("rst_a_done", 128'(done_a),     128'(0));
    chk_reset_b("rst_b");
    rst = 1'b0;

    // Valid before start must not be consumed.
    for (int m = 0; m < 4; m++) in_data_a[m*128 +: 128] = slice_a(m);
    in_valid_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("pre_wren", 128'(wr_en_a),    128'(0));
      chk("pre_rdy",  128'(in_ready_a), 128'(0));
      chk("pre_busy", 128'(busy_a),     128'(0));
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy", 128'(busy_a),     128'(1));
    chk("a_rdy",  128'(in_ready_a), 128'(1));
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      chk("a_wren", 128'(wr_en_a),    128'(1));
      chk("a_addr", 128'(wr_addr_a),  128'(m));
      chk("a_data", wr_data_a,        slice_a(m));
      chk("a_rdy_drain", 128'(in_ready_a), 128'(0));
      chk("a_done_early", 128'(done_a), 128'(0));
    end
    @(negedge clk);
    chk("a_done", 128'(done_a),     128'(1));
    chk("a_busy_end", 128'(busy_a), 128'(0));
    chk("a_wren_end", 128'(wr_en_a), 128'(0));
    chk("a_addr_hold", 128'(wr_addr_a), 128'(3));
    chk("a_fcnt", 128'(flag_cnt_a), 128'(1));
    @(negedge clk);
    chk("a_done_pulse", 128'(done_a), 128'(0));
    chk("a_fcnt_hold", 128'(flag_cnt_a), 128'(1));

    // 2x3 continuous, with a start pulse while busy, then gapped.
    run_cont_b(1'b1);
    run_gap_b();

    // Reset during the second drain beat of the third flag.
    b = 0;
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      exp_rdy = (k == 1) || (k >= 5 && (k - 5) % 4 == 0);
      in_valid_b = 1'b1;
      in_data_b  = beat_b(b);
      if (exp_rdy) b++;
    end
    chk("pre_rst_wren", 128'(wr_en_b), 128'(1));
    chk("pre_rst_addr", 128'(wr_addr_b), 128'(9));
    rst = 1'b1;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk_reset_b("midrst");
    rst = 1'b0;
    run_cont_b(1'b0);

    // Single-module config: one write per cycle.
    b = 0;
    @(negedge clk);
    start_c = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start_c = 1'b0;
      chk("c_rdy",  128'(in_ready_c), 128'(k <= 4));
      chk("c_wren", 128'(wr_en_c),    128'(k >= 2 && k <= 5));
      chk("c_busy", 128'(busy_c),     128'(k <= 5));
      chk("c_done", 128'(done_c),     128'(k == 6));
      if (k >= 2 && k <= 5) begin
        chk("c_addr", 128'(wr_addr_c), 128'(k - 2));
        chk("c_data", wr_data_c, slice_c(k - 2));
      end
      if (k == 6) chk("c_fcnt", 128'(flag_cnt_c), 128'(4));
      in_valid_c = (b < 4);
      in_data_c  = slice_c(b);
      if (k <= 4 && b < 4) b++;
    end
    in_valid_c = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
